// File: rtl/st7789_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : st7789_pkg                                                       |
// | Purpose  : Opcodes, state encoding and coordinate types for the ST7789 seq. |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package st7789_pkg;

  localparam int COORD_W = 9;
  localparam int STATE_W = 3;

  localparam logic [7:0] OP_CASET  = 8'h2A;
  localparam logic [7:0] OP_RASET  = 8'h2B;
  localparam logic [7:0] OP_RAMWR  = 8'h2C;
  localparam logic [7:0] OP_RAMWRC = 8'h3C;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [COORD_W-1:0] coord_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CASET = 3'd1;
  localparam state_t ST_RASET = 3'd2;
  localparam state_t ST_RAMWR = 3'd3;
  localparam state_t ST_SKIP  = 3'd4;

  function automatic state_t decode_cmd(input logic [7:0] op);
    case (op)
      OP_CASET:             return ST_CASET;
      OP_RASET:             return ST_RASET;
      OP_RAMWR, OP_RAMWRC:  return ST_RAMWR;
      default:              return ST_SKIP;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_byte_rx.sv
// +----------------------------------------------------------------------------+
// | Module   : spi_byte_rx                                                      |
// | Purpose  : Mode-0 SPI deserialiser; byte strobe coincides with last bit.   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_byte_rx (
  input  logic       i_spi_clk,
  input  logic       i_rst_n,
  input  logic       i_spi_cs,
  input  logic       i_spi_mosi,
  input  logic       i_spi_dc,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_byte_dc
);

  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;

  always_ff @(posedge i_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 7'd0;
    end else if (!i_spi_cs) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      r_shift   <= {r_shift[5:0], i_spi_mosi};
    end
  end

  // Byte is presented combinationally so the consumer acts on the same edge as the last bit.
  assign o_byte_valid = ~i_spi_cs & (r_bit_cnt == 3'd7);
  assign o_byte       = {r_shift, i_spi_mosi};
  assign o_byte_dc    = i_spi_dc;

endmodule

`default_nettype wire

// File: rtl/st7789_cmd_seq.sv
// +----------------------------------------------------------------------------+
// | Module   : st7789_cmd_seq                                                   |
// | Purpose  : ST7789 command decoder: CASET/RASET windowing and RAMWR pixels.  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module st7789_cmd_seq
  import st7789_pkg::*;
#(
  parameter int H_RES = 480,
  parameter int V_RES = 272
) (
  input  logic         i_spi_clk,
  input  logic         i_rst_n,
  input  logic         i_spi_cs,
  input  logic         i_spi_mosi,
  input  logic         i_spi_dc,
  output logic [15:0]  o_pixel_data,
  output logic [8:0]   o_pixel_x,
  output logic [8:0]   o_pixel_y,
  output logic         o_pixel_we,
  output logic         o_frame_start,
  output logic         o_win_err
);

  localparam coord_t C_XE_RST = COORD_W'(H_RES - 1);
  localparam coord_t C_YE_RST = COORD_W'(V_RES - 1);

  logic       w_byte_valid;
  logic [7:0] w_byte;
  logic       w_byte_dc;

  spi_byte_rx u_rx (
    .i_spi_clk    (i_spi_clk),
    .i_rst_n      (i_rst_n),
    .i_spi_cs     (i_spi_cs),
    .i_spi_mosi   (i_spi_mosi),
    .i_spi_dc     (i_spi_dc),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_byte_dc    (w_byte_dc)
  );

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_sh_cnt;
  coord_t     r_sh_start;
  logic       r_sh_end8;
  coord_t     r_xs, r_xe, r_ys, r_ye;
  coord_t     r_x, r_y;
  logic       r_phase_lo;
  logic [7:0] r_hi;

  logic   w_cmd, w_data, w_ramwr_new, w_win_data, w_win_last, w_win_ok;
  logic   w_commit, w_err, w_pix, w_hi_store;
  coord_t w_end, w_limit;

  always_ff @(posedge i_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_byte_valid && !w_byte_dc) w_next_state = decode_cmd(w_byte);
  end

  always_comb begin
    w_cmd       = w_byte_valid & ~w_byte_dc;
    w_data      = w_byte_valid & w_byte_dc;
    w_ramwr_new = w_cmd & (w_byte == OP_RAMWR);
    w_win_data  = w_data & ((r_state == ST_CASET) | (r_state == ST_RASET));
    w_win_last  = w_win_data & (r_sh_cnt == 3'd3);
    w_end       = {r_sh_end8, w_byte};
    w_limit     = (r_state == ST_CASET) ? C_XE_RST : C_YE_RST;
    w_win_ok    = (r_sh_start <= w_end) && (w_end <= w_limit);
    w_commit    = w_win_last & w_win_ok;
    w_err       = w_win_last & ~w_win_ok;
    w_pix       = w_data & (r_state == ST_RAMWR) & r_phase_lo;
    w_hi_store  = w_data & (r_state == ST_RAMWR) & ~r_phase_lo;
  end

  // Shadow collects start/end; only bit 0 of each MSB byte survives into the 9-bit coordinate.
  always_ff @(posedge i_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh_cnt   <= 3'd0;
      r_sh_start <= '0;
      r_sh_end8  <= 1'b0;
      r_xs       <= '0;
      r_xe       <= C_XE_RST;
      r_ys       <= '0;
      r_ye       <= C_YE_RST;
    end else begin
      if (w_cmd) begin
        r_sh_cnt <= 3'd0;
      end else if (w_win_data && r_sh_cnt != 3'd4) begin
        r_sh_cnt <= r_sh_cnt + 3'd1;
        case (r_sh_cnt)
          3'd0:    r_sh_start[8]   <= w_byte[0];
          3'd1:    r_sh_start[7:0] <= w_byte;
          3'd2:    r_sh_end8       <= w_byte[0];
          default: ;
        endcase
      end
      if (w_commit) begin
        if (r_state == ST_CASET) begin
          r_xs <= r_sh_start;
          r_xe <= w_end;
        end else begin
          r_ys <= r_sh_start;
          r_ye <= w_end;
        end
      end
    end
  end

  always_ff @(posedge i_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_phase_lo <= 1'b0;
      r_hi       <= 8'd0;
    end else begin
      if (w_cmd) r_phase_lo <= 1'b0;
      if (w_ramwr_new) begin
        r_x <= r_xs;
        r_y <= r_ys;
      end
      if (w_hi_store) begin
        r_hi       <= w_byte;
        r_phase_lo <= 1'b1;
      end
      if (w_pix) begin
        r_phase_lo <= 1'b0;
        if (r_x == r_xe) begin
          r_x <= r_xs;
          r_y <= (r_y == r_ye) ? r_ys : r_y + 9'd1;
        end else begin
          r_x <= r_x + 9'd1;
        end
      end
    end
  end

  always_ff @(posedge i_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pixel_data  <= 16'd0;
      o_pixel_x     <= 9'd0;
      o_pixel_y     <= 9'd0;
      o_pixel_we    <= 1'b0;
      o_frame_start <= 1'b0;
      o_win_err     <= 1'b0;
    end else begin
      o_pixel_we    <= w_pix;
      o_frame_start <= w_ramwr_new;
      o_win_err     <= w_err;
      if (w_pix) begin
        o_pixel_data <= {r_hi, w_byte};
        o_pixel_x    <= r_x;
        o_pixel_y    <= r_y;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_st7789_cmd_seq.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_st7789_cmd_seq                                                |
// | Purpose  : Directed self-checking bench for st7789_cmd_seq.                 |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_st7789_cmd_seq;

  logic        clk = 1'b0;
  logic        rst_n, cs, mosi, dc;
  logic [15:0] pixel_data;
  logic [8:0]  pixel_x, pixel_y;
  logic        pixel_we, frame_start, win_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] cap_d[$];
  logic [8:0]  cap_x[$];
  logic [8:0]  cap_y[$];
  int          fs_cnt = 0;
  int          err_cnt = 0;

  always #5 clk = ~clk;

  st7789_cmd_seq #(.H_RES(480), .V_RES(272)) dut (
    .i_spi_clk     (clk),
    .i_rst_n       (rst_n),
    .i_spi_cs      (cs),
    .i_spi_mosi    (mosi),
    .i_spi_dc      (dc),
    .o_pixel_data  (pixel_data),
    .o_pixel_x     (pixel_x),
    .o_pixel_y     (pixel_y),
    .o_pixel_we    (pixel_we),
    .o_frame_start (frame_start),
    .o_win_err     (win_err)
  );

  // Counts high cycles, so a pulse stretched beyond one cycle shows up as an extra event.
  always @(posedge clk) begin
    #1;
    if (pixel_we) begin
      cap_d.push_back(pixel_data);
      cap_x.push_back(pixel_x);
      cap_y.push_back(pixel_y);
    end
    if (frame_start) fs_cnt++;
    if (win_err) err_cnt++;
  end

  task automatic clear_caps();
    cap_d.delete(); cap_x.delete(); cap_y.delete();
    fs_cnt = 0; err_cnt = 0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int hi_idx, input int n, input logic d);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cs = 1'b0; mosi = b[hi_idx - i]; dc = d;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    send_bits(b, 7, 8, d);
  endtask

  task automatic release_cs();
    @(negedge clk); cs = 1'b1; mosi = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_pix(input logic [15:0] p);
    send_byte(p[15:8], 1'b1);
    send_byte(p[7:0], 1'b1);
  endtask

  task automatic check_pix(input string nm, input int idx, input logic [15:0] ed,
                           input logic [8:0] ex, input logic [8:0] ey);
    checks++;
    if (cap_d.size() <= idx) begin
      errors++;
      $display("FAIL %s pixel %0d missing: got %0d pixels, required more", nm, idx, cap_d.size());
    end else if (cap_d[idx] !== ed || cap_x[idx] !== ex || cap_y[idx] !== ey) begin
      errors++;
      $display("FAIL %s pixel %0d: got %h@(%0d,%0d) required %h@(%0d,%0d)",
               nm, idx, cap_d[idx], cap_x[idx], cap_y[idx], ed, ex, ey);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs = 1'b1; mosi = 1'b0; dc = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pixel_data, pixel_x, pixel_y, pixel_we, frame_start, win_err} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%0d/%0d/%b%b%b required all zero",
               pixel_data, pixel_x, pixel_y, pixel_we, frame_start, win_err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    clear_caps();
    send_byte(8'h2C, 1'b0);
    send_pix(16'hF800);
    send_pix(16'h07E0);
    release_cs();
    checks++;
    if (fs_cnt !== 1) begin errors++; $display("FAIL basic_frame_start: got %0d required 1", fs_cnt); end
    checks++;
    if (cap_d.size() !== 2) begin errors++; $display("FAIL basic_count: got %0d required 2", cap_d.size()); end
    check_pix("basic", 0, 16'hF800, 9'd0, 9'd0);
    check_pix("basic", 1, 16'h07E0, 9'd1, 9'd0);
  endtask

  task automatic test_window();
    logic [8:0] ex[7];
    logic [8:0] ey[7];
    ex = '{9'd10, 9'd11, 9'd12, 9'd10, 9'd11, 9'd12, 9'd10};
    ey = '{9'd5, 9'd5, 9'd5, 9'd6, 9'd6, 9'd6, 9'd5};
    clear_caps();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h0A, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h0C, 1'b1);
    send_byte(8'h2B, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h06, 1'b1);
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < 7; i++) send_pix(16'h1000 + 16'(i));
    release_cs();
    checks++;
    if (cap_d.size() !== 7 || err_cnt !== 0) begin
      errors++;
      $display("FAIL window_count: got %0d pixels %0d errs required 7 pixels 0 errs", cap_d.size(), err_cnt);
    end
    for (int i = 0; i < 7; i++) check_pix("window", i, 16'h1000 + 16'(i), ex[i], ey[i]);
    checks++;
    if (pixel_data !== 16'h1006) begin
      errors++;
      $display("FAIL hold_data: got %h required 1006", pixel_data);
    end
  endtask

  task automatic test_win_err();
    clear_caps();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h14, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h0A, 1'b1);
    release_cs();
    checks++;
    if (err_cnt !== 1) begin errors++; $display("FAIL win_err_pulse: got %0d cycles required 1", err_cnt); end
    send_byte(8'h2C, 1'b0);
    send_pix(16'hABCD);
    release_cs();
    check_pix("win_err_keep", 0, 16'hABCD, 9'd10, 9'd5);
  endtask

  task automatic test_partial();
    clear_caps();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h2C, 1'b0);
    send_pix(16'h1357);
    send_pix(16'h2468);
    release_cs();
    checks++;
    if (err_cnt !== 0) begin errors++; $display("FAIL partial_err: got %0d required 0", err_cnt); end
    check_pix("partial", 0, 16'h1357, 9'd10, 9'd5);
    check_pix("partial", 1, 16'h2468, 9'd11, 9'd5);
  endtask

  task automatic test_resume();
    clear_caps();
    send_byte(8'h2C, 1'b0);
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1); send_byte(8'hCC, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'hDD, 1'b1); send_byte(8'hEE, 1'b1);
    release_cs();
    checks++;
    if (cap_d.size() !== 2 || fs_cnt !== 1) begin
      errors++;
      $display("FAIL resume_counts: got %0d pixels %0d frames required 2 and 1", cap_d.size(), fs_cnt);
    end
    check_pix("resume", 0, 16'hAABB, 9'd10, 9'd5);
    check_pix("resume", 1, 16'hDDEE, 9'd11, 9'd5);
  endtask

  task automatic test_cs_gap();
    clear_caps();
    send_byte(8'h2C, 1'b0);
    send_byte(8'h12, 1'b1);
    send_bits(8'h34, 7, 4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); cs = 1'b1; mosi = ~mosi; dc = 1'b0;
    end
    send_bits(8'h34, 3, 4, 1'b1);
    release_cs();
    checks++;
    if (cap_d.size() !== 1) begin errors++; $display("FAIL cs_gap_count: got %0d required 1", cap_d.size()); end
    check_pix("cs_gap", 0, 16'h1234, 9'd10, 9'd5);
  endtask

  task automatic test_reset_mid();
    clear_caps();
    send_byte(8'h2C, 1'b0);
    send_bits(8'hAB, 7, 5, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pixel_data, pixel_x, pixel_y, pixel_we, frame_start, win_err} !== 37'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h/%0d/%0d required zero", pixel_data, pixel_x, pixel_y);
    end
    repeat (2) @(negedge clk);
    cs = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    release_cs();
    checks++;
    if (cap_d.size() !== 0 || fs_cnt !== 1) begin
      errors++;
      $display("FAIL reset_mid_idle: got %0d pixels %0d frames required 0 and 1", cap_d.size(), fs_cnt);
    end
    send_byte(8'h2C, 1'b0);
    send_pix(16'h5678);
    release_cs();
    check_pix("reset_mid_fresh", 0, 16'h5678, 9'd0, 9'd0);
  endtask

  task automatic test_boundary();
    clear_caps();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h01, 1'b1); send_byte(8'hDF, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'hDF, 1'b1);
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'hE0, 1'b1);
    send_byte(8'h2C, 1'b0);
    send_pix(16'hC0DE);
    send_pix(16'hBEEF);
    release_cs();
    checks++;
    if (err_cnt !== 1) begin errors++; $display("FAIL boundary_err: got %0d required 1", err_cnt); end
    check_pix("boundary", 0, 16'hC0DE, 9'd479, 9'd0);
    check_pix("boundary", 1, 16'hBEEF, 9'd479, 9'd1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_window();
    test_win_err();
    test_partial();
    test_resume();
    test_cs_gap();
    test_reset_mid();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/st7789_cmd_seq.md
ST7789_CMD_SEQ -- requirements
Module: st7789_cmd_seq

Interface
REQ-001 Parameter H_RES, default 480, panel width in pixels.
REQ-002 Parameter V_RES, default 272, panel height in pixels.
REQ-003 i_spi_clk  in  1  SPI clock (mode 0), sole clock.
REQ-004 i_rst_n  in  1  reset; asynchronous, active-low.
REQ-005 i_spi_cs  in  1  chip select, active-low, sampled at posedge i_spi_clk.
REQ-006 i_spi_mosi  in  1  serial data, MSB first.
REQ-007 i_spi_dc  in  1  0 = command byte, 1 = data byte; sampled with the byte's last bit.
REQ-008 o_pixel_data  out  16  RGB565 pixel, high byte first on the wire.
REQ-009 o_pixel_x  out  9  column of o_pixel_data.
REQ-010 o_pixel_y  out  9  row of o_pixel_data.
REQ-011 o_pixel_we  out  1  pixel-valid pulse, one i_spi_clk cycle.
REQ-012 o_frame_start  out  1  pulse on RAMWR (0x2C) command decode.
REQ-013 o_win_err  out  1  pulse on rejected CASET/RASET window.

Function
REQ-014 Posedges with i_spi_cs=1 SHALL be ignored: no shift, no count, no state change.
REQ-015 3-bit bit counter SHALL advance on every posedge with i_spi_cs=0 and wrap 7->0; byte complete when counter=7; counter cleared only by reset.
REQ-016 States: IDLE, CASET, RASET, RAMWR, SKIP; any command byte SHALL end the current state and decode anew.
REQ-017 Command decode: 0x2A->CASET, 0x2B->RASET, 0x2C->RAMWR (pointer=(xs,ys), o_frame_start), 0x3C->RAMWR without pointer reload or frame_start, others->SKIP.
REQ-018 SKIP and IDLE SHALL discard data bytes.
REQ-019 CASET/RASET SHALL collect 4 data bytes (start MSB, start LSB, end MSB, end LSB) into a shadow register, lower 9 bits of each 16-bit value kept; further data bytes discarded.
REQ-020 On 4th byte: commit if start<=end and end<H_RES (CASET) / end<V_RES (RASET); else keep previous window and pulse o_win_err.
REQ-021 Command arriving before 4th byte SHALL abandon the shadow; window unchanged, no error.
REQ-022 RAMWR: byte pairs form pixels {hi,lo}; on lo byte o_pixel_data/x/y SHALL be registered and o_pixel_we asserted at the same posedge that samples the lo byte's last bit.
REQ-023 Pointer advance after each pixel: x==xe -> x=xs and (y==ye -> y=ys, else y+1); else x+1.
REQ-024 A lone hi byte pending when a command arrives SHALL be discarded; byte phase reset to hi on every RAMWR entry.
REQ-025 Pulse outputs SHALL be high for exactly one i_spi_clk cycle; level persists while clock is stopped (consumer synchronises).
REQ-026 o_pixel_data/x/y SHALL hold last value between pulses.

Reset
REQ-027 Reset SHALL set: state IDLE, bit counter 0, byte phase hi, window xs=0 xe=H_RES-1 ys=0 ye=V_RES-1, pointer (0,0), all outputs 0.
REQ-028 Reset mid-transfer SHALL abort immediately; no pulse on release.

Structure
REQ-029 Package st7789_pkg SHALL hold opcode constants (0x2A/0x2B/0x2C/0x3C), state encoding, coordinate width 9.
REQ-030 Sub-module spi_byte_rx SHALL contain bit counter, shift register, DC capture, byte-valid strobe.

Verification
REQ-031 Reset, RAMWR, 2 pixels 0xF800,0x07E0 -> frame_start once; we at (0,0)=F800, (1,0)=07E0.
REQ-032 CASET 0,10,0,12; RASET 0,5,0,6; RAMWR; 7 pixels -> coords (10,5)(11,5)(12,5)(10,6)(11,6)(12,6)(10,5).
REQ-033 CASET 0,20,0,10 -> o_win_err 1 cycle; subsequent RAMWR starts at previous xs.
REQ-034 CASET with 2 bytes then RAMWR -> window unchanged, no error.
REQ-035 RAMWR, 3 data bytes, NOP(0x00), 0x3C, 2 bytes -> 2 pixels total, second at next pointer, one frame_start.
REQ-036 CS high with clocks mid-pixel, then remaining bits with CS low -> pixel assembled correctly; i_rst_n low mid-byte -> outputs 0, state IDLE.
